// File: rtl/lmcnt_pkg.sv
// Shared definitions for the local-memory command sequencer: memory-select
// codes, field widths, command field offsets and the sequencer state type.
package lmcnt_pkg;

  localparam int ADDR_W = 10;
  localparam int SEL_W  = 2;
  localparam int CMD_W  = 46;

  localparam logic [SEL_W-1:0] MSEL_M0 = 2'b00;
  localparam logic [SEL_W-1:0] MSEL_M1 = 2'b01;
  localparam logic [SEL_W-1:0] MSEL_M2 = 2'b10;
  localparam logic [SEL_W-1:0] MSEL_M3 = 2'b11;

  // Low bit of each field inside a command word (A_SEL sits at the MSBs)
  localparam int OFS_A_SEL  = 44;
  localparam int OFS_B_SEL  = 42;
  localparam int OFS_C_SEL  = 40;
  localparam int OFS_M1POS  = 30;
  localparam int OFS_M1SIZE = 20;
  localparam int OFS_M2POS  = 10;
  localparam int OFS_M3POS  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_ARM,
    ST_WAIT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [SEL_W-1:0]  a_sel;
    logic [SEL_W-1:0]  b_sel;
    logic [SEL_W-1:0]  c_sel;
    logic [ADDR_W-1:0] m1pos;
    logic [ADDR_W-1:0] m1size;
    logic [ADDR_W-1:0] m2pos;
    logic [ADDR_W-1:0] m3pos;
  } cmd_t;

  // Split a raw command word into its named fields
  function automatic cmd_t unpack_cmd(input logic [CMD_W-1:0] raw);
    cmd_t c;
    c.a_sel  = raw[OFS_A_SEL  +: SEL_W];
    c.b_sel  = raw[OFS_B_SEL  +: SEL_W];
    c.c_sel  = raw[OFS_C_SEL  +: SEL_W];
    c.m1pos  = raw[OFS_M1POS  +: ADDR_W];
    c.m1size = raw[OFS_M1SIZE +: ADDR_W];
    c.m2pos  = raw[OFS_M2POS  +: ADDR_W];
    c.m3pos  = raw[OFS_M3POS  +: ADDR_W];
    return c;
  endfunction

endpackage

// File: rtl/lmcnt_seq_fifo.sv
// Command queue for the sequencer: DEPTH x WIDTH synchronous FIFO with
// push, pop and a single-cycle flush. Push while full and pop while empty
// are ignored; flush has priority over both.
module lmcnt_seq_fifo
  import lmcnt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; the array itself needs no reset because count guards it
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/lmcnt_seq.sv
// lmcnt_seq: queues CPU layer commands and runs each one on the local
// memory controller as SOFT_RESET -> START -> wait for FINISH -> DONE.
// Optional watchdog: define LMCNT_SEQ_TIMEOUT_EN to abandon a command that
// never finishes after TIMEOUT_CYC cycles in WAIT and raise sticky TIMEOUT.
module lmcnt_seq
  import lmcnt_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [CMD_W-1:0]  CMD_DATA,
  input  logic              ABORT,
  output logic              BUSY,
  output logic              DONE,
  output logic [7:0]        DONE_CNT,
  output logic              LM_SOFT_RESET,
  output logic              LM_START,
  input  logic              LM_FINISH,
  output logic [SEL_W-1:0]  MSEL_INPUTA_SEL,
  output logic [SEL_W-1:0]  MSEL_INPUTB_SEL,
  output logic [SEL_W-1:0]  MSEL_OUTPUTC_SEL,
  output logic [ADDR_W-1:0] M1POS,
  output logic [ADDR_W-1:0] M1SIZE,
  output logic [ADDR_W-1:0] M2POS,
`ifdef LMCNT_SEQ_TIMEOUT_EN
  output logic              TIMEOUT,
`endif
  output logic [ADDR_W-1:0] M3POS
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lmcnt_seq: DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 8191) begin : g_bad_timeout
    $error("lmcnt_seq: TIMEOUT_CYC must fit the 13-bit watchdog");
  end

  state_t           state;
  state_t           next_state;
  cmd_t             cfg;
  logic [CMD_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             timeout_hit;
  logic [7:0]       done_cnt;

  // ABORT flushes the queue, so any push or pop in that cycle is dropped
  assign fifo_push = CMD_VALID && CMD_READY && !ABORT;
  assign fifo_pop  = (state == ST_IDLE) && !fifo_empty && !ABORT;

  lmcnt_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk   (CLK),
    .reset (RESET),
    .flush (ABORT),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (CMD_DATA),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef LMCNT_SEQ_TIMEOUT_EN
  localparam logic [12:0] WD_LAST = 13'(TIMEOUT_CYC - 1);
  logic [12:0] wd_cnt;
  logic        timeout_flag;

  assign timeout_hit = (state == ST_WAIT) && !LM_FINISH && (wd_cnt == WD_LAST);
  assign TIMEOUT     = timeout_flag;

  // Watchdog counts WAIT cycles and restarts from zero on every entry to WAIT
  always_ff @(posedge CLK) begin
    if (RESET || state != ST_WAIT) wd_cnt <= '0;
    else                           wd_cnt <= wd_cnt + 1'b1;
  end

  // Sticky timeout indication, cleared only by RESET or ABORT
  always_ff @(posedge CLK) begin
    if (RESET || ABORT)   timeout_flag <= 1'b0;
    else if (timeout_hit) timeout_flag <= 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; ABORT overrides every state, FINISH only counts in WAIT
  always_comb begin
    next_state = state;
    if (ABORT) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (!fifo_empty) next_state = ST_CLR;
        ST_CLR:  next_state = ST_ARM;
        ST_ARM:  next_state = ST_WAIT;
        ST_WAIT: begin
          if (LM_FINISH)        next_state = ST_DONE;
          else if (timeout_hit) next_state = ST_IDLE;
        end
        ST_DONE: next_state = ST_IDLE;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Controller strobes; RESET never produces a soft reset towards the controller
  always_comb begin
    LM_SOFT_RESET = 1'b0;
    LM_START      = 1'b0;
    DONE          = 1'b0;
    if (!RESET) begin
      if (ABORT) begin
        LM_SOFT_RESET = 1'b1;
      end else begin
        case (state)
          ST_CLR:  LM_SOFT_RESET = 1'b1;
          ST_ARM:  LM_START      = 1'b1;
          ST_WAIT: LM_SOFT_RESET = timeout_hit && !LM_FINISH;
          ST_DONE: DONE          = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Configuration latched at pop and held until the next pop
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cfg <= '{a_sel: MSEL_M0, b_sel: MSEL_M0, c_sel: MSEL_M0, default: '0};
    end else if (fifo_pop) begin
      cfg <= unpack_cmd(fifo_head);
    end
  end

  // Completed-command counter, wraps naturally at 8 bits
  always_ff @(posedge CLK) begin
    if (RESET)     done_cnt <= '0;
    else if (DONE) done_cnt <= done_cnt + 1'b1;
  end

  assign CMD_READY        = !fifo_full;
  assign BUSY             = (state != ST_IDLE) || !fifo_empty;
  assign DONE_CNT         = done_cnt;
  assign MSEL_INPUTA_SEL  = cfg.a_sel;
  assign MSEL_INPUTB_SEL  = cfg.b_sel;
  assign MSEL_OUTPUTC_SEL = cfg.c_sel;
  assign M1POS            = cfg.m1pos;
  assign M1SIZE           = cfg.m1size;
  assign M2POS            = cfg.m2pos;
  assign M3POS            = cfg.m3pos;

endmodule

// File: tb/tb_lmcnt_seq.sv
// Testbench for lmcnt_seq: a behavioural controller model answers START
// with FINISH after a per-command latency; expected event cycles come from
// plain arithmetic over push times and latencies.
module tb_lmcnt_seq;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [45:0] CMD_DATA = '0;
  logic        ABORT = 1'b0;
  logic        BUSY;
  logic        DONE;
  logic [7:0]  DONE_CNT;
  logic        LM_SOFT_RESET;
  logic        LM_START;
  logic        LM_FINISH = 1'b0;
  logic [1:0]  MSEL_INPUTA_SEL, MSEL_INPUTB_SEL, MSEL_OUTPUTC_SEL;
  logic [9:0]  M1POS, M1SIZE, M2POS, M3POS;
`ifdef LMCNT_SEQ_TIMEOUT_EN
  logic        TIMEOUT;
`endif

  lmcnt_seq #(.DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .CMD_VALID        (CMD_VALID),
    .CMD_READY        (CMD_READY),
    .CMD_DATA         (CMD_DATA),
    .ABORT            (ABORT),
    .BUSY             (BUSY),
    .DONE             (DONE),
    .DONE_CNT         (DONE_CNT),
    .LM_SOFT_RESET    (LM_SOFT_RESET),
    .LM_START         (LM_START),
    .LM_FINISH        (LM_FINISH),
    .MSEL_INPUTA_SEL  (MSEL_INPUTA_SEL),
    .MSEL_INPUTB_SEL  (MSEL_INPUTB_SEL),
    .MSEL_OUTPUTC_SEL (MSEL_OUTPUTC_SEL),
    .M1POS            (M1POS),
    .M1SIZE           (M1SIZE),
    .M2POS            (M2POS),
`ifdef LMCNT_SEQ_TIMEOUT_EN
    .TIMEOUT          (TIMEOUT),
`endif
    .M3POS            (M3POS)
  );

  always #5 CLK = ~CLK;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Event log filled by the monitor
  int          n_start = 0;
  int          n_sr = 0;
  int          n_done = 0;
  int          order_err = 0;
  logic        last_was_sr = 1'b0;
  logic        prev_sr = 1'b0;
  logic        prev_start = 1'b0;
  logic        rst_seen = 1'b0;
  int          done_log[$];
  logic [45:0] cfg_log[$];

  // Controller model state: latency per START in order, 0 means never finish
  int lat_tab[64];
  int lat_rd = 0;
  int fin_timer = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [45:0] cfg_out();
    return {MSEL_INPUTA_SEL, MSEL_INPUTB_SEL, MSEL_OUTPUTC_SEL, M1POS, M1SIZE, M2POS, M3POS};
  endfunction

  // Monitor: log strobes mid-cycle and note whether START follows a SOFT_RESET
  always @(negedge CLK) begin
    rst_seen   = RESET;
    prev_sr    = LM_SOFT_RESET && !RESET;
    prev_start = LM_START && !RESET;
    if (!RESET) begin
      if (LM_START) begin
        n_start++;
        if (!last_was_sr) order_err++;
        cfg_log.push_back(cfg_out());
      end
      if (LM_SOFT_RESET) n_sr++;
      if (DONE) begin
        n_done++;
        done_log.push_back(cyc);
      end
      last_was_sr = LM_SOFT_RESET;
    end
  end

  // Controller model: FINISH is a level that only a soft reset clears
  always @(posedge CLK) begin
    #1;
    if (rst_seen || prev_sr) begin
      LM_FINISH = 1'b0;
      fin_timer = 0;
    end
    if (prev_start) begin
      fin_timer = lat_tab[lat_rd];
      lat_rd = lat_rd + 1;
    end else if (fin_timer > 0) begin
      fin_timer--;
      if (fin_timer == 0) LM_FINISH = 1'b1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [45:0] rand_cmd();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[45:0];
  endfunction

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] time limit");
  end

  initial begin
    logic [45:0] cmd_a;
    logic [45:0] cmds[6];
    logic [45:0] c_cmds[3];
    int          pc[6];
    int          lat[6];
    int          exp_done[6];
    int          prev_done, pop, start, pop1;
    int          t0, done_at, acc, base_done, base_cfg, base_start, base_sr;
    int          exp_done_cnt;
    int          lat_wr;

    // ---- reset state ----
    repeat (3) tick();
    RESET = 1'b0;
    @(negedge CLK);
    check_output("rst_ready", CMD_READY, 1);
    check_output("rst_busy", BUSY, 0);
    check_output("rst_done", DONE, 0);
    check_output("rst_done_cnt", DONE_CNT, 0);
    check_output("rst_strobes", {LM_SOFT_RESET, LM_START}, 0);
    check_output("rst_cfg", cfg_out(), 0);
`ifdef LMCNT_SEQ_TIMEOUT_EN
    check_output("rst_timeout", TIMEOUT, 0);
`endif

    // ---- single command, exact latency ----
    tick();
    t0 = cyc;
    cmd_a = {2'b01, 2'b10, 2'b11, 10'h010, 10'h3FF, 10'($urandom()), 10'($urandom())};
    lat_tab[0] = 1026;
    lat_wr = 1;
    CMD_VALID = 1'b1;
    CMD_DATA = cmd_a;
    @(negedge CLK);
    check_output("a_ready_c0", CMD_READY, 1);
    tick();
    CMD_VALID = 1'b0;
    @(negedge CLK);
    check_output("a_busy_c1", BUSY, 1);
    check_output("a_sr_c1", LM_SOFT_RESET, 0);
    tick();
    @(negedge CLK);
    check_output("a_sr_c2", LM_SOFT_RESET, 1);
    check_output("a_cfg_c2", cfg_out(), cmd_a);
    tick();
    @(negedge CLK);
    check_output("a_start_c3", {LM_START, LM_SOFT_RESET}, 2'b10);
    done_at = -1;
    for (int k = 0; k < 1200; k++) begin
      tick();
      @(negedge CLK);
      if (DONE) begin
        done_at = cyc - t0;
        break;
      end
    end
    check_output("a_done_cycle", done_at, 1031);
    tick();
    @(negedge CLK);
    exp_done_cnt = 1;
    check_output("a_done_cnt", DONE_CNT, exp_done_cnt);
    check_output("a_done_pulse_len", DONE, 0);
    check_output("a_busy_after", BUSY, 0);
    check_output("a_cfg_hold", cfg_out(), cmd_a);

    // ---- queue fill, full-FIFO push during pop, ordering, stale FINISH ----
    base_done  = n_done;
    base_cfg   = cfg_log.size();
    base_start = n_start;
    base_sr    = n_sr;
    for (int i = 0; i < 6; i++) begin
      cmds[i] = rand_cmd();
      lat[i] = (i == 0) ? int'($urandom_range(3, 15)) : int'($urandom_range(1, 10));
      lat_tab[lat_wr + i] = lat[i];
    end
    lat_wr += 6;
    for (int i = 0; i < 5; i++) pc[i] = i;
    // Reference timing: pop when idle and non-empty, SR/START follow, DONE after FINISH
    prev_done = -1000;
    pop1 = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) pc[5] = pop1 + 1;
      pop = (pc[i] + 1 > prev_done + 1) ? pc[i] + 1 : prev_done + 1;
      if (i == 1) pop1 = pop;
      start = pop + 2;
      exp_done[i] = start + 2 + lat[i];
      prev_done = exp_done[i];
    end
    tick();
    t0 = cyc;
    for (int i = 0; i < 5; i++) begin
      CMD_VALID = 1'b1;
      CMD_DATA = cmds[i];
      tick();
    end
    CMD_DATA = cmds[5];
    @(negedge CLK);
    check_output("b_ready_full", CMD_READY, 0);
    check_output("b_busy_full", BUSY, 1);
    acc = -1;
    for (int k = 0; k < 300; k++) begin
      tick();
      @(negedge CLK);
      if (CMD_READY) begin
        acc = cyc - t0;
        break;
      end
    end
    tick();
    CMD_VALID = 1'b0;
    check_output("b_push_after_pop", acc, pc[5]);
    for (int k = 0; k < 400 && n_done < base_done + 6; k++) tick();
    check_output("b_done_count", n_done - base_done, 6);
    for (int i = 0; i < 6; i++) begin
      check_output($sformatf("b_done_cycle%0d", i),
                   (base_done + i < done_log.size()) ? done_log[base_done + i] - t0 : -1,
                   exp_done[i]);
      check_output($sformatf("b_cfg_order%0d", i),
                   (base_cfg + i < cfg_log.size()) ? cfg_log[base_cfg + i] : '1,
                   cmds[i]);
    end
    check_output("b_start_count", n_start - base_start, 6);
    check_output("b_sr_count", n_sr - base_sr, 6);
    check_output("b_sr_before_start", order_err, 0);
    @(negedge CLK);
    exp_done_cnt += 6;
    check_output("b_done_cnt", DONE_CNT, exp_done_cnt);

    // ---- ABORT during WAIT with two commands queued, concurrent push ----
    for (int i = 0; i < 3; i++) c_cmds[i] = rand_cmd();
    lat_tab[lat_wr] = 0;
    lat_wr += 1;
    tick();
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      CMD_VALID = 1'b1;
      CMD_DATA = c_cmds[i];
      tick();
    end
    CMD_VALID = 1'b0;
    repeat (7) tick();
    CMD_VALID = 1'b1;
    CMD_DATA = rand_cmd();
    ABORT = 1'b1;
    base_start = n_start;
    base_done  = n_done;
    @(negedge CLK);
    check_output("c_abort_sr", LM_SOFT_RESET, 1);
    check_output("c_abort_start", LM_START, 0);
    check_output("c_abort_done", DONE, 0);
    tick();
    ABORT = 1'b0;
    CMD_VALID = 1'b0;
    @(negedge CLK);
    check_output("c_busy_after", BUSY, 0);
    check_output("c_ready_after", CMD_READY, 1);
    check_output("c_done_cnt_kept", DONE_CNT, exp_done_cnt);
    repeat (30) tick();
    @(negedge CLK);
    check_output("c_no_new_start", n_start - base_start, 0);
    check_output("c_no_done", n_done - base_done, 0);
    check_output("c_cfg_kept", cfg_out(), c_cmds[0]);
    check_output("c_still_idle", BUSY, 0);

`ifdef LMCNT_SEQ_TIMEOUT_EN
    // ---- watchdog: first command never finishes, second runs normally ----
    lat_tab[lat_wr] = 0;
    lat_tab[lat_wr + 1] = 3;
    lat_wr += 2;
    cmds[0] = rand_cmd();
    cmds[1] = rand_cmd();
    tick();
    t0 = cyc;
    CMD_VALID = 1'b1;
    CMD_DATA = cmds[0];
    tick();
    CMD_DATA = cmds[1];
    tick();
    CMD_VALID = 1'b0;
    repeat (16) tick();
    @(negedge CLK);
    check_output("d_sr_before_limit", LM_SOFT_RESET, 0);
    tick();
    @(negedge CLK);
    check_output("d_sr_at_limit", LM_SOFT_RESET, 1);
    check_output("d_no_done", DONE, 0);
    tick();
    @(negedge CLK);
    check_output("d_timeout_set", TIMEOUT, 1);
    check_output("d_done_cnt_kept", DONE_CNT, exp_done_cnt);
    tick();
    @(negedge CLK);
    check_output("d_next_cmd_sr", LM_SOFT_RESET, 1);
    done_at = -1;
    for (int k = 0; k < 100; k++) begin
      tick();
      @(negedge CLK);
      if (DONE) begin
        done_at = cyc - t0;
        break;
      end
    end
    check_output("d_next_done_cycle", done_at, 27);
    tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    @(negedge CLK);
    exp_done_cnt += 1;
    check_output("d_done_cnt", DONE_CNT, exp_done_cnt);
    check_output("d_timeout_cleared", TIMEOUT, 0);
`endif

    // ---- RESET in the middle of a command ----
    lat_tab[lat_wr] = 0;
    lat_wr += 1;
    tick();
    CMD_VALID = 1'b1;
    CMD_DATA = rand_cmd();
    tick();
    CMD_VALID = 1'b0;
    repeat (5) tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    base_start = n_start;
    @(negedge CLK);
    check_output("e_done_cnt_reset", DONE_CNT, 0);
    check_output("e_busy_reset", BUSY, 0);
    check_output("e_cfg_reset", cfg_out(), 0);
    check_output("e_strobes_reset", {LM_SOFT_RESET, LM_START, DONE}, 0);
    check_output("e_ready_reset", CMD_READY, 1);
    repeat (5) tick();
    @(negedge CLK);
    check_output("e_stays_idle", n_start - base_start, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
